// File: rtl/sr_drift_pkg.sv
// sr_drift_pkg: shared constants for the OU drift bank.
// Holds cfg_sel codes, LFSR taps, seeds and the sweep FSM state type.
package sr_drift_pkg;

    localparam logic [2:0] SEL_CENTER = 3'd0;
    localparam logic [2:0] SEL_DRIFT  = 3'd1;
    localparam logic [2:0] SEL_TAU    = 3'd2;
    localparam logic [2:0] SEL_AMP    = 3'd3;
    localparam logic [2:0] SEL_STATE  = 3'd4;
    localparam logic [2:0] SEL_LIMIT  = 3'd5;

    // Feedback taps: bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [15:0] SEED_BASE   = 16'hF1D9;
    localparam logic [15:0] SEED_ZERO   = 16'hACE1;
    localparam logic [15:0] SEED_STRIDE = 16'h9E37;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_DONE
    } sweep_st_e;

    // An all-zero LFSR would lock up, so it is replaced.
    function automatic logic [15:0] chan_seed(
        input int          ch,
        input logic [15:0] ofs
    );
        logic [15:0] s;
        s = SEED_BASE ^ ofs ^ 16'(ch * SEED_STRIDE);
        return (s == 16'h0000) ? SEED_ZERO : s;
    endfunction

endpackage

// File: rtl/sr_ou_step.sv
// sr_ou_step: one Ornstein-Uhlenbeck update of a single channel.
// Inputs: channel state, center, drift_max, tau_inv, amp, lfsr.
// Outputs: clamped next state and next lfsr (combinational).
module sr_ou_step
    import sr_drift_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int FRAC  = 14
) (
    input  logic signed [WIDTH-1:0] state_i,
    input  logic signed [WIDTH-1:0] center_i,
    input  logic signed [WIDTH-1:0] drift_i,
    input  logic signed [WIDTH-1:0] tau_i,
    input  logic signed [WIDTH-1:0] amp_i,
    input  logic [15:0]             lfsr_i,
    output logic signed [WIDTH-1:0] state_o,
    output logic [15:0]             lfsr_o
);

    localparam int EW = WIDTH + 2;
    localparam int PW = 2 * WIDTH;
    localparam int NW = WIDTH + 10;

    logic signed [9:0]    mag;
    logic signed [9:0]    nsig;
    logic signed [NW-1:0] n_prod;
    logic signed [PW-1:0] r_prod;
    logic signed [EW-1:0] noise;
    logic signed [EW-1:0] rev;
    logic signed [EW-1:0] sum;
    logic signed [EW-1:0] lo;
    logic signed [EW-1:0] hi;
    logic signed [EW-1:0] res;

    always_comb begin
        mag    = {2'b00, lfsr_i[7:0]};
        nsig   = lfsr_i[15] ? -mag : mag;
        n_prod = NW'(nsig) * NW'(amp_i);
        noise  = EW'(n_prod >>> 7);
        r_prod = PW'(tau_i) * (PW'(center_i) - PW'(state_i));
        rev    = EW'(r_prod >>> FRAC);
        // Two guard bits keep the sum exact before clamping.
        sum    = EW'(state_i) + rev + noise;
        lo     = EW'(center_i) - EW'(drift_i);
        hi     = EW'(center_i) + EW'(drift_i);
        if (sum < lo) begin
            res = lo;
        end else if (sum > hi) begin
            res = hi;
        end else begin
            res = sum;
        end
        state_o = WIDTH'(res);
        lfsr_o  = {lfsr_i[14:0], ^(lfsr_i & LFSR_TAPS)};
    end

endmodule

// File: rtl/sr_ou_drift_bank.sv
// sr_ou_drift_bank: bank of OU drift channels swept once per tick.
// Ports: clk, rst, clk_en, freeze, cfg_* write port, busy/upd_valid/
// overrun status, packed channel states and scaled states.
module sr_ou_drift_bank
    import sr_drift_pkg::*;
#(
    parameter int          WIDTH       = 18,
    parameter int          FRAC        = 14,
    parameter int          NUM_CH      = 5,
    parameter int          DECIMATE    = 64,
    parameter int          DEF_CENTER  = 16384,
    parameter int          DEF_DRIFT   = 3277,
    parameter int          DEF_TAU     = 8,
    parameter int          DEF_AMP     = 80,
    parameter int          SCALE_MUL   = 31,
    parameter int          SCALE_SH    = 15,
    parameter logic [15:0] SEED_OFFSET = 16'h0000,
    localparam int         CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clk_en,
    input  logic                     freeze,
    input  logic                     cfg_we,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [2:0]               cfg_sel,
    input  logic signed [WIDTH-1:0]  cfg_data,
    output logic                     cfg_ready,
    output logic                     busy,
    output logic                     upd_valid,
    output logic                     overrun,
    output logic [NUM_CH*WIDTH-1:0]  state_packed,
    output logic [NUM_CH*WIDTH-1:0]  scaled_packed
);

    localparam int CNT_W = $clog2(DECIMATE);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    sweep_st_e        st_q, st_d;
    logic [CH_W-1:0]  idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             upd_valid_q, upd_valid_d;
    logic             overrun_q, overrun_d;

    logic signed [WIDTH-1:0] center_q [NUM_CH];
    logic signed [WIDTH-1:0] center_d [NUM_CH];
    logic signed [WIDTH-1:0] drift_q  [NUM_CH];
    logic signed [WIDTH-1:0] drift_d  [NUM_CH];
    logic signed [WIDTH-1:0] tau_q    [NUM_CH];
    logic signed [WIDTH-1:0] tau_d    [NUM_CH];
    logic signed [WIDTH-1:0] amp_q    [NUM_CH];
    logic signed [WIDTH-1:0] amp_d    [NUM_CH];
    logic signed [WIDTH-1:0] state_q  [NUM_CH];
    logic signed [WIDTH-1:0] state_d  [NUM_CH];
    logic signed [WIDTH-1:0] scaled_q [NUM_CH];
    logic signed [WIDTH-1:0] scaled_d [NUM_CH];
    logic [15:0]             lfsr_q   [NUM_CH];
    logic [15:0]             lfsr_d   [NUM_CH];

    logic                    tick;
    logic                    cfg_ok;
    logic signed [WIDTH-1:0] step_state;
    logic [15:0]             step_lfsr;

    function automatic logic signed [WIDTH-1:0] scale(
        input logic signed [WIDTH-1:0] s
    );
        logic signed [WIDTH+31:0] p;
        p = (WIDTH+32)'(s) * (WIDTH+32)'(SCALE_MUL);
        return WIDTH'(p >>> SCALE_SH);
    endfunction

    sr_ou_step #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_step (
        .state_i  (state_q[idx_q]),
        .center_i (center_q[idx_q]),
        .drift_i  (drift_q[idx_q]),
        .tau_i    (tau_q[idx_q]),
        .amp_i    (amp_q[idx_q]),
        .lfsr_i   (lfsr_q[idx_q]),
        .state_o  (step_state),
        .lfsr_o   (step_lfsr)
    );

    always_comb begin
        cnt_d       = cnt_q;
        st_d        = st_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        upd_valid_d = 1'b0;
        overrun_d   = overrun_q;
        center_d    = center_q;
        drift_d     = drift_q;
        tau_d       = tau_q;
        amp_d       = amp_q;
        state_d     = state_q;
        scaled_d    = scaled_q;
        lfsr_d      = lfsr_q;

        tick = clk_en && (cnt_q == '0);
        if (clk_en) begin
            if (cnt_q == CNT_W'(DECIMATE - 1)) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Writes land before a coincident sweep reads the arrays.
        cfg_ok = cfg_we && !busy_q
              && (int'(cfg_ch) < NUM_CH)
              && (cfg_sel < SEL_LIMIT);
        if (cfg_ok) begin
            unique case (cfg_sel)
                SEL_CENTER: center_d[cfg_ch] = cfg_data;
                SEL_DRIFT:  drift_d[cfg_ch]  = cfg_data;
                SEL_TAU:    tau_d[cfg_ch]    = cfg_data;
                SEL_AMP:    amp_d[cfg_ch]    = cfg_data;
                SEL_STATE:  state_d[cfg_ch]  = cfg_data;
                default: ;
            endcase
        end

        unique case (st_q)
            ST_IDLE: begin
                if (tick && !freeze) begin
                    st_d   = ST_SWEEP;
                    idx_d  = '0;
                    busy_d = 1'b1;
                end
            end
            ST_SWEEP: begin
                state_d[idx_q]  = step_state;
                lfsr_d[idx_q]   = step_lfsr;
                scaled_d[idx_q] = scale(step_state);
                if (idx_q == CH_W'(NUM_CH - 1)) begin
                    st_d        = ST_DONE;
                    idx_d       = '0;
                    upd_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
                if (tick) begin
                    overrun_d = 1'b1;
                end
            end
            ST_DONE: begin
                st_d   = ST_IDLE;
                busy_d = 1'b0;
                if (tick) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                st_d   = ST_IDLE;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            st_q        <= ST_IDLE;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            upd_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                center_q[c] <= WIDTH'(DEF_CENTER);
                drift_q[c]  <= WIDTH'(DEF_DRIFT);
                tau_q[c]    <= WIDTH'(DEF_TAU);
                amp_q[c]    <= WIDTH'(DEF_AMP);
                state_q[c]  <= WIDTH'(DEF_CENTER);
                scaled_q[c] <= scale(WIDTH'(DEF_CENTER));
                lfsr_q[c]   <= chan_seed(c, SEED_OFFSET);
            end
        end else begin
            cnt_q       <= cnt_d;
            st_q        <= st_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            upd_valid_q <= upd_valid_d;
            overrun_q   <= overrun_d;
            center_q    <= center_d;
            drift_q     <= drift_d;
            tau_q       <= tau_d;
            amp_q       <= amp_d;
            state_q     <= state_d;
            scaled_q    <= scaled_d;
            lfsr_q      <= lfsr_d;
        end
    end

    always_comb begin
        state_packed  = '0;
        scaled_packed = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_packed[i*WIDTH +: WIDTH]  = state_q[i];
            scaled_packed[i*WIDTH +: WIDTH] = scaled_q[i];
        end
    end

    assign cfg_ready = !busy_q;
    assign busy      = busy_q;
    assign upd_valid = upd_valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_sr_ou_drift_bank.sv
// tb_sr_ou_drift_bank: scoreboard bench for sr_ou_drift_bank.
// Reference model uses plain integer arithmetic per channel.
module tb_sr_ou_drift_bank;

    localparam int W   = 18;
    localparam int NCH = 5;
    localparam int DEC = 4;
    localparam int CHW = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  clk_en;
    logic                  freeze;
    logic                  cfg_we;
    logic [CHW-1:0]        cfg_ch;
    logic [2:0]            cfg_sel;
    logic signed [W-1:0]   cfg_data;
    logic                  cfg_ready;
    logic                  busy;
    logic                  upd_valid;
    logic                  overrun;
    logic [NCH*W-1:0]      state_packed;
    logic [NCH*W-1:0]      scaled_packed;

    always #5 clk = ~clk;

    sr_ou_drift_bank #(
        .NUM_CH   (NCH),
        .DECIMATE (DEC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .freeze        (freeze),
        .cfg_we        (cfg_we),
        .cfg_ch        (cfg_ch),
        .cfg_sel       (cfg_sel),
        .cfg_data      (cfg_data),
        .cfg_ready     (cfg_ready),
        .busy          (busy),
        .upd_valid     (upd_valid),
        .overrun       (overrun),
        .state_packed  (state_packed),
        .scaled_packed (scaled_packed)
    );

    typedef struct {
        longint st[NCH];
        longint sc[NCH];
        int     due;
    } exp_t;

    exp_t   exp_q[$];
    longint m_center[NCH];
    longint m_drift[NCH];
    longint m_tau[NCH];
    longint m_amp[NCH];
    longint m_state[NCH];
    longint m_scaled[NCH];
    longint m_lfsr[NCH];
    int     m_cnt;
    int     m_busy_left;
    bit     m_ovr;
    bit     sweep_started;
    int     cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     upd_seen = 0;

    task automatic chk(string nm, longint act, longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    function automatic longint dut_state(int i);
        logic signed [W-1:0] v;
        v = state_packed[i*W +: W];
        return longint'(v);
    endfunction

    function automatic longint dut_scaled(int i);
        logic signed [W-1:0] v;
        v = scaled_packed[i*W +: W];
        return longint'(v);
    endfunction

    task automatic model_reset();
        longint s;
        for (int c = 0; c < NCH; c++) begin
            m_center[c] = 16384;
            m_drift[c]  = 3277;
            m_tau[c]    = 8;
            m_amp[c]    = 80;
            m_state[c]  = 16384;
            m_scaled[c] = (longint'(16384) * 31) >>> 15;
            s = 64'hF1D9 ^ ((c * 64'h9E37) & 64'hFFFF);
            m_lfsr[c] = (s == 0) ? 64'hACE1 : s;
        end
        m_cnt = 0;
        m_busy_left = 0;
        m_ovr = 0;
        sweep_started = 0;
        exp_q.delete();
    endtask

    task automatic model_sweep();
        exp_t   e;
        longint lf, m, n, noise, rev, nx, lo, hi, fb;
        for (int c = 0; c < NCH; c++) begin
            lf = m_lfsr[c];
            m  = lf % 256;
            n  = (lf >= 32768) ? -m : m;
            noise = (n * m_amp[c]) >>> 7;
            rev = (m_tau[c] * (m_center[c] - m_state[c])) >>> 14;
            nx = m_state[c] + rev + noise;
            lo = m_center[c] - m_drift[c];
            hi = m_center[c] + m_drift[c];
            if (nx < lo) nx = lo;
            else if (nx > hi) nx = hi;
            m_state[c]  = nx;
            m_scaled[c] = (nx * 31) >>> 15;
            fb = ((lf >> 15) ^ (lf >> 13) ^ (lf >> 12) ^ (lf >> 10)) & 1;
            m_lfsr[c] = ((lf << 1) | fb) & 64'hFFFF;
            e.st[c] = nx;
            e.sc[c] = m_scaled[c];
        end
        e.due = cyc + NCH;
        exp_q.push_back(e);
    endtask

    task automatic step(bit r, bit en, bit frz, bit we,
                        int ch, int sel, longint data);
        bit was_busy;
        bit tk;
        rst      = r;
        clk_en   = en;
        freeze   = frz;
        cfg_we   = we;
        cfg_ch   = CHW'(ch);
        cfg_sel  = 3'(sel);
        cfg_data = W'(data);
        @(posedge clk);
        cyc++;
        sweep_started = 0;
        if (r) begin
            model_reset();
        end else begin
            was_busy = (m_busy_left > 0);
            tk = en && (m_cnt == 0);
            if (en) m_cnt = (m_cnt + 1) % DEC;
            if (m_busy_left > 0) m_busy_left--;
            if (we && !was_busy && ch < NCH && sel < 5) begin
                case (sel)
                    0: m_center[ch] = data;
                    1: m_drift[ch]  = data;
                    2: m_tau[ch]    = data;
                    3: m_amp[ch]    = data;
                    default: m_state[ch] = data;
                endcase
            end
            if (tk) begin
                if (was_busy) begin
                    m_ovr = 1;
                end else if (!frz) begin
                    model_sweep();
                    m_busy_left = NCH + 1;
                    sweep_started = 1;
                end
            end
        end
        @(negedge clk);
        chk("cfg_ready", longint'(cfg_ready), (m_busy_left == 0) ? 1 : 0);
        chk("busy", longint'(busy), (m_busy_left > 0) ? 1 : 0);
        chk("overrun", longint'(overrun), longint'(m_ovr));
        if (m_busy_left == 0) begin
            for (int c = 0; c < NCH; c++) begin
                chk("idle_state", dut_state(c), m_state[c]);
                chk("idle_scaled", dut_scaled(c), m_scaled[c]);
            end
        end
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic start_sweep();
        bit ok;
        ok = 0;
        for (int k = 0; k < DEC + NCH + 4 && !ok; k++) begin
            step(0, 1, 0, 0, 0, 0, 0);
            ok = sweep_started;
        end
        chk("sweep_start", longint'(ok), 1);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (upd_valid === 1'b1) begin
            upd_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL upd_unexpected: got pulse expected none (cycle %0d)",
                         cyc);
            end else begin
                e = exp_q.pop_front();
                chk("upd_time", cyc, e.due);
                for (int c = 0; c < NCH; c++) begin
                    chk("upd_state", dut_state(c), e.st[c]);
                    chk("upd_scaled", dut_scaled(c), e.sc[c]);
                end
            end
        end
    end

    function automatic longint rand_data(int sel);
        case (sel)
            0: return longint'($urandom_range(0, 120000)) - 60000;
            1: return longint'($urandom_range(0, 60000));
            2: return longint'($urandom_range(0, 16384));
            3: return longint'($urandom_range(0, 2000));
            4: return longint'($urandom_range(0, 240000)) - 120000;
            default: return longint'($urandom_range(0, 131071)) - 65536;
        endcase
    endfunction

    initial begin : stim
        int  n0;
        int  sel;
        rst = 1; clk_en = 0; freeze = 0; cfg_we = 0;
        cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
        model_reset();

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_upd_valid", longint'(upd_valid), 0);
        chk("rst_state0", dut_state(0), 16384);
        chk("rst_scaled0", dut_scaled(0), 15);

        // Pure reversion: one full step back to center.
        step(0, 0, 0, 1, 0, 3, 0);
        step(0, 0, 0, 1, 0, 2, 16384);
        step(0, 0, 0, 1, 0, 4, 17384);
        chk("state_write_unclamped", dut_state(0), 17384);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("tick_starts_sweep", longint'(busy), 1);
        idle(NCH + 3);
        chk("revert_state", dut_state(0), 16384);
        chk("revert_scaled", dut_scaled(0), 15);

        // Freeze across ten ticks.
        n0 = upd_seen;
        for (int k = 0; k < 10 * DEC; k++) step(0, 1, 1, 0, 0, 0, 0);
        idle(2);
        chk("freeze_no_upd", upd_seen, n0);
        chk("freeze_no_overrun", longint'(overrun), 0);

        // Zero drift pins every state to its center.
        for (int c = 0; c < NCH; c++) step(0, 0, 0, 1, c, 1, 0);
        for (int k = 0; k < 100 * DEC * 2; k++)
            step(0, (k % 2) == 0, 0, 0, 0, 0, 0);
        idle(NCH + 3);
        for (int c = 0; c < NCH; c++)
            chk("drift0_center", dut_state(c), 16384);

        // Write during a sweep is dropped; the same write in idle lands.
        start_sweep();
        step(0, 0, 0, 1, 2, 4, 5000);
        idle(NCH + 3);
        chk("busy_write_ignored", dut_state(2), 16384);
        step(0, 0, 0, 1, 2, 4, 5000);
        chk("idle_write", dut_state(2), 5000);
        step(0, 0, 0, 1, 2, 4, 5);
        step(0, 0, 0, 1, 6, 4, 777);
        chk("bad_ch_ignored", dut_state(2), 5);

        // Randomized traffic.
        for (int k = 0; k < 700; k++) begin
            sel = $urandom_range(0, 7);
            step(0, $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7), sel,
                 rand_data(sel));
        end
        idle(NCH + 3);

        // Back-to-back clk_en forces overrun; sweeps keep completing.
        step(1, 0, 0, 0, 0, 0, 0);
        n0 = upd_seen;
        for (int k = 0; k < 30; k++) step(0, 1, 0, 0, 0, 0, 0);
        idle(NCH + 3);
        chk("overrun_set", longint'(overrun), 1);
        chk("overrun_sweeps_done", longint'(upd_seen > n0 + 2), 1);

        // Reset mid-sweep at idx 1.
        start_sweep();
        step(0, 0, 0, 0, 0, 0, 0);
        n0 = upd_seen;
        step(1, 0, 0, 0, 0, 0, 0);
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_upd", longint'(upd_valid), 0);
        chk("midrst_overrun", longint'(overrun), 0);
        idle(NCH + 3);
        chk("midrst_no_upd", upd_seen, n0);
        chk("midrst_state", dut_state(1), 16384);

        for (int k = 0; k < 50 && exp_q.size() > 0; k++) idle(1);
        chk("drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sr_ou_drift_bank.md
SR_OU_DRIFT_BANK -- requirements
Module: sr_ou_drift_bank

Interface
REQ-001 The parameter WIDTH SHALL default to 18 and set the signed state/config word width.
REQ-002 The parameter FRAC SHALL default to 14 and set the fractional bits of the state, center and tau_inv values.
REQ-003 The parameter NUM_CH SHALL default to 5 and set the channel count, legal range 1..16; CH_W = max(1, clog2(NUM_CH)).
REQ-004 The parameter DECIMATE SHALL default to 64 and set the number of clk_en pulses per update tick, legal range 2..256.
REQ-005 Parameters DEF_CENTER, DEF_DRIFT, DEF_TAU and DEF_AMP SHALL default to 16384, 3277, 8 and 80 and set the per-channel reset configuration.
REQ-006 Parameters SCALE_MUL and SCALE_SH SHALL default to 31 and 15 and set the integer-scaling factor.
REQ-007 Parameter SEED_OFFSET SHALL default to 16'h0000 and SHALL be XORed into every channel seed.
REQ-008 clk  in  1  sole clock; all state changes on its rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 clk_en  in  1  sample-rate enable that advances the decimation counter.
REQ-011 freeze  in  1  while high, update ticks are suppressed and states hold.
REQ-012 cfg_we  in  1  configuration write strobe.
REQ-013 cfg_ch  in  CH_W  target channel of the write.
REQ-014 cfg_sel  in  3  target field: 0 center, 1 drift_max, 2 tau_inv, 3 noise_amp, 4 state; 5-7 are reserved.
REQ-015 cfg_data  in  WIDTH signed  write data.
REQ-016 cfg_ready  out  1  high when a write is accepted; equals !busy.
REQ-017 busy  out  1  high while a sweep is in progress.
REQ-018 upd_valid  out  1  one-cycle pulse when a sweep completes.
REQ-019 overrun  out  1  sticky flag set when a tick arrives while busy.
REQ-020 state_packed  out  NUM_CH*WIDTH  channel states, with channel 0 in the LSBs.
REQ-021 scaled_packed  out  NUM_CH*WIDTH  (state*SCALE_MUL)>>>SCALE_SH for each channel.

Function
REQ-022 The decimation counter SHALL increment on each clk_en, wrap from DECIMATE-1 to 0, and assert tick on the clk_en in which the counter equals 0.
REQ-023 The FSM SHALL have three states: IDLE, SWEEP and DONE.
REQ-024 IDLE SHALL go to SWEEP on tick when freeze is low; tick with freeze high SHALL be discarded and SHALL NOT set overrun.
REQ-025 SWEEP SHALL process channel idx = 0..NUM_CH-1, one channel per clk cycle independent of clk_en, then go to DONE; DONE SHALL pulse upd_valid and return to IDLE, so upd_valid occurs NUM_CH+1 cycles after the tick cycle.
REQ-026 In each channel step, noise SHALL equal (lfsr[15] ? -lfsr[7:0] : lfsr[7:0]) * amp >>> 7.
REQ-027 In each channel step, reversion SHALL equal (tau_inv*(center-state)) >>> FRAC, using a 2*WIDTH-bit product.
REQ-028 The new state SHALL equal state+reversion+noise, computed WIDTH+2 bits wide and clamped to [center-drift_max, center+drift_max]; the lower bound is checked first.
REQ-029 The channel LFSR SHALL shift left with feedback bit15^bit13^bit12^bit10 in the same cycle as the state update.
REQ-030 A tick while busy SHALL be dropped and SHALL set overrun; overrun SHALL clear only on rst.
REQ-031 A write with cfg_we high while busy, with cfg_ch >= NUM_CH, or with cfg_sel >= 5 SHALL be ignored with no side effect.
REQ-032 An accepted write SHALL update the selected field at the next edge; a state write SHALL NOT be clamped until the next sweep.
REQ-033 When cfg_we and tick coincide in IDLE, the write SHALL take effect and the sweep SHALL start in the same edge, with the sweep using the written value.
REQ-034 state_packed and scaled_packed SHALL be registered and SHALL update per channel as that channel is processed.

Reset
REQ-035 On rst, all channels SHALL load center=DEF_CENTER, drift_max=DEF_DRIFT, tau_inv=DEF_TAU, amp=DEF_AMP and state=DEF_CENTER.
REQ-036 On rst, channel LFSR ch SHALL load 16'hF1D9^SEED_OFFSET^(ch*16'h9E37), or 16'hACE1 if that value is zero.
REQ-037 On rst, the FSM SHALL enter IDLE and the decimation counter, idx, busy, upd_valid and overrun SHALL all clear to 0.
REQ-038 An rst asserted mid-sweep SHALL abort the sweep with no partial upd_valid.

Structure
REQ-039 A shared package sr_drift_pkg SHALL hold the cfg_sel codes, LFSR taps, default seed, zero-seed substitute and seed stride.
REQ-040 The per-channel arithmetic (REQ-026..029) SHALL be one combinational sub-module, sr_ou_step, instantiated once and time-shared across channels.
REQ-041 Per-channel fields SHALL be register arrays indexed by idx or cfg_ch.

Verification
REQ-042 Scenario: NUM_CH=2, DECIMATE=4; write amp=0, tau_inv=16384, state=17384 to ch0 -> after one sweep, ch0 state=16384 and scaled=15.
REQ-043 Scenario: write drift_max=0 to all channels and run 100 ticks -> every state equals its center on each upd_valid.
REQ-044 Scenario: hold freeze high across 10 ticks -> no upd_valid, states unchanged, overrun=0.
REQ-045 Scenario: write during SWEEP -> cfg_ready=0 and the field is unchanged; the same write in IDLE takes effect.
REQ-046 Scenario: NUM_CH=8 with clk_en every cycle and DECIMATE=2 -> overrun=1 and sweeps still complete.
REQ-047 Scenario: assert rst at SWEEP idx=1 -> all outputs return to reset values one cycle later; SEED_OFFSET=16'hF1D9 gives ch0 LFSR=16'hACE1.
